// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes,
// FSM states, error causes and request classification helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RMW_WRITE = 2'd2
  } lsu_state_t;

  // Stores only know B/H/W; loads additionally know BU/HU.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 > F3_W);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  // Only meaningful for a legal funct3; halves need even, words need 4-aligned.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'd1:    return off[0];
      2'd2:    return (off != 2'd0);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Request/response/memory bundle between the pipeline, the LSU and the data memory.
interface lsu_mem_stage_if #(parameter int ADDR_WIDTH = 10);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_din;
  logic [31:0]           mem_dout;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  err_valid;
  logic [1:0]            err_cause;
  logic [31:0]           err_addr;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    output req_ready, mem_we, mem_addr, mem_din,
           resp_valid, resp_rdata, err_valid, err_cause, err_addr
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    input  req_ready, mem_we, mem_addr, mem_din,
           resp_valid, resp_rdata, err_valid, err_cause, err_addr
  );

endinterface

// File: rtl/lsu_mem_stage_lane_align.sv
// Byte/half lane logic shared by the load path and the sub-word store
// read-modify-write path.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [31:0] byte_word;
  logic [31:0] half_word;

  assign byte_shift = {offset, 3'b000};
  assign half_shift = {offset[1], 4'b0000};
  assign byte_word  = word >> byte_shift;
  assign half_word  = word >> half_shift;

  // Extract the addressed lane and sign/zero extend it to 32 bits.
  always_comb begin
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{byte_word[7]}}, byte_word[7:0]};
      F3_H:    load_data = {{16{half_word[15]}}, half_word[15:0]};
      F3_BU:   load_data = {24'd0, byte_word[7:0]};
      F3_HU:   load_data = {16'd0, half_word[15:0]};
      default: load_data = word;
    endcase
  end

  // Replace the target lane of the old word with the low bits of the store data.
  always_comb begin
    merged = wdata;
    case (funct3)
      F3_B: merged = (word & ~(32'h0000_00FF << byte_shift))
                   | ({24'd0, wdata[7:0]} << byte_shift);
      F3_H: merged = (word & ~(32'h0000_FFFF << half_shift))
                   | ({16'd0, wdata[15:0]} << half_shift);
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit in front of a word-addressed, word-write-enable
// data memory. Loads take two cycles, SW one, SB/SH a read-modify-write.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  lsu_mem_stage_if.slave  bus
);

  lsu_state_t            state;
  logic [1:0]            lat_off;
  logic [2:0]            lat_f3;
  logic [31:0]           lat_wdata;
  logic [ADDR_WIDTH-1:0] lat_waddr;
  logic                  resp_valid_q;
  logic [31:0]           resp_rdata_q;
  logic                  err_valid_q;
  logic [1:0]            err_cause_q;
  logic [31:0]           err_addr_q;

  logic [ADDR_WIDTH-1:0] req_waddr;
  logic                  accept;
  logic                  bad_f3;
  logic                  misal;
  logic                  has_err;
  logic                  mem_we_int;
  logic [31:0]           load_data;
  logic [31:0]           merged;

  assign req_waddr = bus.req_addr[ADDR_WIDTH+1:2];
  assign accept    = (state == IDLE) && bus.req_valid;
  assign bad_f3    = f3_illegal(bus.req_we, bus.req_funct3);
  assign misal     = f3_misaligned(bus.req_funct3, bus.req_addr[1:0]);
  assign has_err   = bad_f3 || misal;

  lsu_lane_align u_lane (
    .word      (bus.mem_dout),
    .offset    (lat_off),
    .funct3    (lat_f3),
    .wdata     (lat_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  // Memory port: pass-through of the request except during the RMW write cycle.
  always_comb begin
    mem_we_int   = 1'b0;
    bus.mem_addr = req_waddr;
    bus.mem_din  = bus.req_wdata;
    case (state)
      IDLE:      mem_we_int = accept && bus.req_we && !has_err && (bus.req_funct3 == F3_W);
      RMW_WRITE: begin
        mem_we_int   = 1'b1;
        bus.mem_addr = lat_waddr;
        bus.mem_din  = merged;
      end
      default:   mem_we_int = 1'b0;
    endcase
  end

  // The write strobe is also gated by reset so an abandoned RMW never writes.
  assign bus.mem_we     = mem_we_int && rst_n;
  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.err_valid  = err_valid_q;
  assign bus.err_cause  = err_cause_q;
  assign bus.err_addr   = err_addr_q;

  // Control FSM with registered response and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      lat_off      <= '0;
      lat_f3       <= '0;
      lat_wdata    <= '0;
      lat_waddr    <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      err_valid_q  <= 1'b0;
      err_cause_q  <= 2'b00;
      err_addr_q   <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      err_valid_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (has_err) begin
              err_valid_q <= 1'b1;
              err_cause_q <= bad_f3 ? ERR_ILLEGAL : ERR_MISALIGN;
              err_addr_q  <= bus.req_addr;
            end else begin
              lat_off   <= bus.req_addr[1:0];
              lat_f3    <= bus.req_funct3;
              lat_wdata <= bus.req_wdata;
              lat_waddr <= req_waddr;
              if (!bus.req_we)
                state <= LOAD_WAIT;
              else if (bus.req_funct3 != F3_W)
                state <= RMW_WRITE;
            end
          end
        end
        LOAD_WAIT: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= load_data;
          state        <= IDLE;
        end
        RMW_WRITE: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed plus randomized bench for lsu_mem_stage against a byte-array
// reference memory and a synchronous-read word memory model.
module tb_lsu_mem_stage;

  logic clk;
  logic rst_n;
  int   test_count;
  int   fail_count;

  lsu_mem_stage_if #(.ADDR_WIDTH(10)) bus ();

  lsu_mem_stage #(.ADDR_WIDTH(10)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Data memory: one-cycle read latency, bench-side preload port.
  logic [31:0] tb_mem [0:1023];
  logic [31:0] mem_q;
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_din;
    else if (pre_we) tb_mem[pre_addr] <= pre_data;
    mem_q <= tb_mem[bus.mem_addr];
  end
  assign bus.mem_dout = mem_q;

  // Reference model: little-endian byte array covering the 4 KiB address window.
  logic [7:0] ref_bytes [0:4095];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_word(input int word_idx);
    return {ref_bytes[word_idx*4+3], ref_bytes[word_idx*4+2],
            ref_bytes[word_idx*4+1], ref_bytes[word_idx*4]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int word_idx, input logic [31:0] data);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = word_idx[9:0];
    pre_data = data;
    for (int k = 0; k < 4; k++) ref_bytes[word_idx*4+k] = data[k*8 +: 8];
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issue one request and check every cycle until the unit is idle again.
  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    logic        illegal;
    logic        misal;
    int          size;
    int          word_idx;
    int          byte_idx;
    logic [31:0] mask;
    logic [31:0] exp_load;
    logic [31:0] exp_word;

    illegal  = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    size     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    misal    = !illegal && ((addr % size) != 0);
    word_idx = int'(addr[11:2]);
    byte_idx = int'(addr[11:0]);
    mask     = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);

    exp_load = 32'd0;
    if (!illegal && !misal && !we) begin
      for (int k = 0; k < size; k++) exp_load |= 32'(ref_bytes[byte_idx+k]) << (8*k);
      if (f3 < 3'd4 && size < 4 && exp_load[8*size-1]) exp_load |= ~mask;
    end
    if (!illegal && !misal && we)
      for (int k = 0; k < size; k++) ref_bytes[byte_idx+k] = wdata[k*8 +: 8];
    exp_word = ref_word(word_idx);

    // Cycle T: request presented and accepted.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    #1;
    checkOutput("ready_T", 32'(bus.req_ready), 32'd1);
    checkOutput("maddr_T", 32'(bus.mem_addr), 32'(word_idx));
    checkOutput("mwe_T", 32'(bus.mem_we), 32'(we && !illegal && !misal && size == 4));
    if (we && !illegal && !misal && size == 4) checkOutput("mdin_T", bus.mem_din, wdata);

    // Cycle T+1.
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    if (illegal || misal) begin
      checkOutput("err_valid", 32'(bus.err_valid), 32'd1);
      checkOutput("err_cause", 32'(bus.err_cause), illegal ? 32'd2 : 32'd1);
      checkOutput("err_addr", bus.err_addr, addr);
      checkOutput("ready_err", 32'(bus.req_ready), 32'd1);
      checkOutput("resp_err", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      #1;
      checkOutput("err_pulse", 32'(bus.err_valid), 32'd0);
    end else if (we && size == 4) begin
      checkOutput("ready_sw", 32'(bus.req_ready), 32'd1);
      checkOutput("mem_sw", tb_mem[word_idx], exp_word);
      checkOutput("err_sw", 32'(bus.err_valid), 32'd0);
      checkOutput("resp_sw", 32'(bus.resp_valid), 32'd0);
    end else if (we) begin
      checkOutput("ready_rmw", 32'(bus.req_ready), 32'd0);
      checkOutput("mwe_rmw", 32'(bus.mem_we), 32'd1);
      checkOutput("maddr_rmw", 32'(bus.mem_addr), 32'(word_idx));
      checkOutput("mdin_rmw", bus.mem_din, exp_word);
      @(negedge clk);
      #1;
      checkOutput("ready_rmw2", 32'(bus.req_ready), 32'd1);
      checkOutput("mwe_rmw2", 32'(bus.mem_we), 32'd0);
      checkOutput("mem_rmw", tb_mem[word_idx], exp_word);
      checkOutput("resp_rmw", 32'(bus.resp_valid), 32'd0);
    end else begin
      checkOutput("ready_ld", 32'(bus.req_ready), 32'd0);
      checkOutput("resp_ld1", 32'(bus.resp_valid), 32'd0);
      checkOutput("mwe_ld", 32'(bus.mem_we), 32'd0);
      @(negedge clk);
      #1;
      checkOutput("resp_ld2", 32'(bus.resp_valid), 32'd1);
      checkOutput("rdata_ld", bus.resp_rdata, exp_load);
      checkOutput("ready_ld2", 32'(bus.req_ready), 32'd1);
    end
  endtask

  initial begin
    test_count     = 0;
    fail_count     = 0;
    rst_n          = 1'b0;
    pre_we         = 1'b0;
    pre_addr       = '0;
    pre_data       = '0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'd0;

    // Reset values.
    #1;
    checkOutput("rst_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst_resp", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_err", 32'(bus.err_valid), 32'd0);
    checkOutput("rst_rdata", bus.resp_rdata, 32'd0);
    checkOutput("rst_cause", 32'(bus.err_cause), 32'd0);
    checkOutput("rst_eaddr", bus.err_addr, 32'd0);
    checkOutput("rst_mwe", 32'(bus.mem_we), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int w = 0; w < 16; w++) preload(w, $urandom);
    preload(5, 32'h8899_AABB);

    // Directed loads from word 5.
    applyStimulus(1'b0, 3'd0, 32'h15, 32'd0);
    checkOutput("lb_val", bus.resp_rdata, 32'hFFFF_FFAA);
    applyStimulus(1'b0, 3'd4, 32'h15, 32'd0);
    applyStimulus(1'b0, 3'd1, 32'h16, 32'd0);
    checkOutput("lh_val", bus.resp_rdata, 32'hFFFF_8899);
    applyStimulus(1'b0, 3'd5, 32'h14, 32'd0);
    applyStimulus(1'b0, 3'd2, 32'h14, 32'd0);
    checkOutput("lw_val", bus.resp_rdata, 32'h8899_AABB);

    // Sub-word stores via read-modify-write.
    applyStimulus(1'b1, 3'd0, 32'h17, 32'h1234_5677);
    checkOutput("sb_word", tb_mem[5], 32'h7799_AABB);
    applyStimulus(1'b1, 3'd1, 32'h14, 32'h0000_CAFE);
    checkOutput("sh_word", tb_mem[5], 32'h7799_CAFE);

    // Word store followed by load of the same word.
    applyStimulus(1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 3'd2, 32'h20, 32'd0);
    checkOutput("sw_lw_val", bus.resp_rdata, 32'hDEAD_BEEF);

    // Rejected requests.
    applyStimulus(1'b0, 3'd2, 32'h22, 32'd0);
    applyStimulus(1'b0, 3'd3, 32'h20, 32'd0);
    applyStimulus(1'b1, 3'd3, 32'h21, 32'd0);
    applyStimulus(1'b1, 3'd1, 32'h13, 32'd0);

    // Reset in the middle of an SB: write must be abandoned.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h19;
    bus.req_wdata  = 32'h0000_0055;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    checkOutput("rstmid_mwe_pre", 32'(bus.mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_mwe", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rstmid_mem", tb_mem[6], ref_word(6));
    checkOutput("rstmid_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rstmid_resp", 32'(bus.resp_valid), 32'd0);

    // Randomized traffic over 16 words, with random high address bits to exercise wrap.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end

    for (int w = 0; w < 16; w++) checkOutput("final_mem", tb_mem[w], ref_word(w));

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit in the MEM stage, directly upstream of the word-addressed data memory.
- Accepts byte-addressed RV32I load/store requests from EX/MEM and drives the memory's word address, write enable and store data.
- Formats load results with byte/half extraction and sign/zero extension.
- The memory has only word write enables, so SB/SH are performed as a two-cycle read-modify-write.
- Produces load responses for MEM/WB, plus a ready/stall signal and an error pulse.

Parameters:
- ADDR_WIDTH, 10: word-address width of the attached data memory; byte-address bits [ADDR_WIDTH+1:2] select the word.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present; accepted in the cycle req_valid && req_ready.
- req_ready  out  1  high only in IDLE; the pipeline stalls while low.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2).
- req_addr  in  32  byte address; bits above ADDR_WIDTH+1 are ignored.
- req_wdata  in  32  store data (rs2).
- mem_we  out  1  memory write enable (combinational).
- mem_addr  out  ADDR_WIDTH  memory word address (combinational).
- mem_din  out  32  memory write data (combinational).
- mem_dout  in  32  memory read data; valid the cycle after the address is presented.
- resp_valid  out  1  one-cycle pulse carrying load data.
- resp_rdata  out  32  formatted load result, registered.
- err_valid  out  1  one-cycle pulse; the request was rejected with no memory access.
- err_cause  out  2  01 misaligned, 10 illegal funct3.
- err_addr  out  32  byte address of the rejected request.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; resp_valid, err_valid = 0; resp_rdata, err_addr = 0; err_cause=00.
  - mem_we is forced to 0 while rst_n=0.
  - A reset during LOAD_WAIT or RMW_WRITE abandons the operation; no write is issued.
- States: IDLE, LOAD_WAIT, RMW_WRITE.
- Load (accepted in cycle T):
  - In T, mem_addr = req_addr[ADDR_WIDTH+1:2]; the byte offset and funct3 are latched; next state LOAD_WAIT.
  - In T+1, mem_dout is sliced by offset: byte lane = offset*8; half lane = offset[1]*16.
  - Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - The result is registered at the end of T+1, so resp_valid=1 in T+2 and state returns to IDLE. Load-to-use latency is 2 cycles.
- SW (accepted in T): mem_we=1, mem_din=req_wdata in T; no state change; single cycle; no resp_valid.
- SB/SH (accepted in T):
  - T: read the word (mem_we=0); latch word address, offset, funct3 and wdata; next state RMW_WRITE.
  - T+1: mem_we=1, mem_din = mem_dout with the target byte/half lane replaced by wdata[7:0] or wdata[15:0]; return to IDLE.
- req_ready=0 in LOAD_WAIT and RMW_WRITE. Requests presented then are not accepted and must be held by upstream.
- In IDLE, a new request may be accepted in the same cycle that resp_valid is high.
- Misaligned requests: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Accepted in one cycle with no memory access (mem_we=0).
  - err_valid=1, err_cause=01, err_addr=req_addr in T+1. State stays IDLE.
- Illegal funct3: load funct3 3/6/7, or store funct3 >=3. Same handling as misaligned, with err_cause=10.
- Error priority: illegal funct3 is checked before misalignment.
- When idle or not accepting: mem_we=0, mem_addr=req word address, mem_din=req_wdata.
- Address wrap: word address is truncated to ADDR_WIDTH bits; no range error.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - state enum (IDLE, LOAD_WAIT, RMW_WRITE).
  - err_cause localparams (ERR_MISALIGN, ERR_ILLEGAL).
- Sub-module lsu_lane_align (combinational):
  - load extract/extend.
  - store lane merge (word, offset, funct3, wdata -> merged word).
  - Shared by the load and RMW paths.

Test Plan:
- Preload word 5 = 0x8899AABB. LB at addr 0x15 -> resp_valid in T+2, resp_rdata=0xFFFFFFAA; LBU at 0x15 -> 0x000000AA.
- Same word: LH at 0x16 -> 0xFFFF8899; LHU at 0x14 -> 0x0000AABB; LW at 0x14 -> 0x8899AABB.
- SB wdata=0x12345677 at 0x17 -> req_ready low for 1 cycle, mem_we in T+1 only, word 5 = 0x7799AABB. A following SH 0xCAFE at 0x14 -> 0x7799CAFE.
- SW 0xDEADBEEF to 0x20 then immediate LW 0x20 -> resp 0xDEADBEEF; SW completes in 1 cycle with req_ready held high.
- LW at 0x22 -> mem_we=0, no resp_valid, err_valid=1 with cause 01 and err_addr=0x22 in T+1. Load funct3=3 -> cause 10.
- SB accepted, rst_n pulled low in T+1 -> mem_we=0 immediately, memory word unchanged, state IDLE and req_ready=1 after release.
